// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, NOP encoding and stage register type
package pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with next-PC mux and IF/ID register
import pipe_pkg::*;

module if_stage #(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    output logic            imem_en_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    // pc_q is the address whose data is on imem_rdata_i this cycle
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            rd_ok_q;
    if_id_t          if_id_q;
    if_id_t          if_id_d;

    // The memory has no side effects, so re-reading the held word on a stall is free
    assign imem_en_o   = 1'b1;
    assign imem_addr_o = pc_d;

    // Next fetch address: reset, then redirect, then stall, then sequential
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (rst) begin
            pc_d = RESET_PC;
        end else if (jump_en_i) begin
            pc_d = word_align(jump_tgt_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: a redirect or flush discards the wrong-path word in rdata
    always_comb begin
        if_id_d = if_id_q;
        if (rst) begin
            if_id_d.pc    = '0;
            if_id_d.instr = INSTR_NOP;
            if_id_d.valid = 1'b0;
        end else if (jump_en_i || flush_i) begin
            if_id_d.instr = INSTR_NOP;
            if_id_d.valid = 1'b0;
        end else if (!stall_i) begin
            if_id_d.pc    = pc_q;
            if_id_d.instr = imem_rdata_i;
            if_id_d.valid = rd_ok_q;
        end
    end

    // State update; rd_ok_q records that a read was issued on the previous edge.
    // The read of RESET_PC issued while in reset is already good, so the first
    // post-reset cycle delivers a live instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rd_ok_q <= imem_en_o;
            if_id_q <= if_id_d;
        end else begin
            pc_q    <= pc_d;
            rd_ok_q <= imem_en_o;
            if_id_q <= if_id_d;
        end
    end

    assign pc_o    = if_id_q.pc;
    assign valid_o = if_id_q.valid;
    assign instr_o = if_id_q.valid ? if_id_q.instr : INSTR_NOP;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and random checks of if_stage against a delivery-order model
module tb_if_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RPC_A   = 32'h0000_0000;
    localparam logic [31:0] RPC_B   = 32'hFFFF_FFF8;
    localparam logic [31:0] MEM_OFS = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        jump_en_i;
    logic [31:0] jump_tgt_i;

    logic        en_a, en_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] pc_a, pc_b, instr_a, instr_b;
    logic        valid_a, valid_b;

    int n_assert = 0;
    int n_fail   = 0;

    // model: per DUT, the PC of the next instruction due to be delivered,
    // and the expected IF/ID contents
    logic [31:0] next_pc [2];
    logic [31:0] exp_pc  [2];
    logic        exp_v   [2];
    logic        pc_known[2];

    if_stage #(.RESET_PC(RPC_A)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .jump_en_i(jump_en_i), .jump_tgt_i(jump_tgt_i),
        .imem_en_o(en_a), .imem_addr_o(addr_a), .imem_rdata_i(rdata_a),
        .pc_o(pc_a), .instr_o(instr_a), .valid_o(valid_a)
    );

    if_stage #(.RESET_PC(RPC_B)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .jump_en_i(jump_en_i), .jump_tgt_i(jump_tgt_i),
        .imem_en_o(en_b), .imem_addr_o(addr_b), .imem_rdata_i(rdata_b),
        .pc_o(pc_b), .instr_o(instr_b), .valid_o(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memories whose word at address a is a+0x100
    always @(posedge clk) begin
        if (en_a) rdata_a <= addr_a + MEM_OFS;
        if (en_b) rdata_b <= addr_b + MEM_OFS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check the fetch address, clock, check IF/ID
    task automatic step(input logic r, input logic s, input logic f,
                        input logic j, input logic [31:0] t);
        logic [31:0] exp_addr;
        logic [31:0] obs_addr, obs_pc, obs_instr;
        logic        obs_v, obs_en;
        rst = r; stall_i = s; flush_i = f; jump_en_i = j; jump_tgt_i = t;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (r)      exp_addr = (k == 0) ? RPC_A : RPC_B;
            else if (j) exp_addr = t & 32'hFFFF_FFFC;
            else if (s) exp_addr = next_pc[k];
            else        exp_addr = next_pc[k] + 32'd4;
            obs_addr = (k == 0) ? addr_a : addr_b;
            obs_en   = (k == 0) ? en_a : en_b;
            chk($sformatf("imem_addr[%0d]", k), obs_addr, exp_addr);
            chk($sformatf("imem_en[%0d]", k), {31'd0, obs_en}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                exp_v[k] = 1'b0; exp_pc[k] = 32'd0; pc_known[k] = 1'b1;
                next_pc[k] = (k == 0) ? RPC_A : RPC_B;
            end else if (j) begin
                exp_v[k] = 1'b0; pc_known[k] = 1'b0;
                next_pc[k] = t & 32'hFFFF_FFFC;
            end else if (f) begin
                exp_v[k] = 1'b0; pc_known[k] = 1'b0;
                if (!s) next_pc[k] = next_pc[k] + 32'd4;
            end else if (!s) begin
                exp_v[k] = 1'b1; exp_pc[k] = next_pc[k]; pc_known[k] = 1'b1;
                next_pc[k] = next_pc[k] + 32'd4;
            end
            obs_v     = (k == 0) ? valid_a : valid_b;
            obs_pc    = (k == 0) ? pc_a : pc_b;
            obs_instr = (k == 0) ? instr_a : instr_b;
            chk($sformatf("valid[%0d]", k), {31'd0, obs_v}, {31'd0, exp_v[k]});
            chk($sformatf("instr[%0d]", k), obs_instr, exp_v[k] ? exp_pc[k] + MEM_OFS : NOP);
            if (pc_known[k]) chk($sformatf("pc[%0d]", k), obs_pc, exp_pc[k]);
        end
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; jump_en_i = 1'b0; jump_tgt_i = '0;
        @(negedge clk);

        // reset, then sequential fetch from RESET_PC (B wraps through zero)
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("release_pc", pc_a, 32'h0);
        chk("release_instr", instr_a, 32'h100);
        chk("wrap_pc0", pc_b, 32'hFFFF_FFF8);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc1", pc_b, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_pc2", pc_b, 32'h0);
        chk("seq_pc8", pc_a, 32'h8);

        // stall three cycles holding pc 0x8, then resume at 0xC
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("stall_hold_pc", pc_a, 32'h8);
            chk("stall_hold_instr", instr_a, 32'h108);
        end
        step(0, 0, 0, 0, 0);
        chk("stall_resume", pc_a, 32'hC);

        // jump to 0x43 while pc_q is 0x10: one bubble, then 0x40
        step(0, 0, 0, 1, 32'h43);
        chk("jump_bubble", {31'd0, valid_a}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("jump_target", pc_a, 32'h40);

        // jump and stall together: jump wins
        step(0, 1, 0, 1, 32'h80);
        step(0, 0, 0, 0, 0);
        chk("jump_stall_target", pc_a, 32'h80);
        step(0, 0, 0, 0, 0);

        // flush alone, flush with stall, then reset during stall+flush
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("mid_reset_instr", instr_a, NOP);
        step(0, 0, 0, 0, 0);
        chk("mid_reset_restart", pc_a, RPC_A);

        // random control mix
        for (int i = 0; i < 400; i++) begin
            logic r, s, f, j;
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 10);
            j = ($urandom_range(0, 99) < 10);
            step(r, s, f, j, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
